jesd207_burst_ctrl: RTL and testbench

//  Sequences one JESD207 burst on the fclk side of the FIFO/RAM datapath.

---
 rtl/jesd207_pkg.sv | 38 +++
 rtl/jesd207_burst_ctrl_if.sv | 42 ++++
 rtl/jesd207_cyc_timer.sv | 46 ++++
 rtl/jesd207_burst_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_jesd207_burst_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jesd207_pkg.sv
// ---------------------------------------------------------------------------
// jesd207_pkg
// Shared definitions for the JESD207 burst controller:
//   state_e      - burst sequencer states
//   DEF_*        - default widths and timing constants
//   TMR_WID      - width of the shared cycle timer
//   cyc_to_tmr() - converts a cycle-count parameter to a timer load value
// Optional feature macro used by the controller: JESD_LEVEL_MODE_EN
// ---------------------------------------------------------------------------
package jesd207_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_ON = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TRANS = 3'd4,
    ST_STOP  = 3'd5,
    ST_GUARD = 3'd6
  } state_e;

  localparam int   DEF_CNT_WID   = 16;
  localparam int   DEF_SETUP_CYC = 2;
  localparam int   DEF_LEAD_CYC  = 2;
  localparam int   DEF_GUARD_CYC = 4;
  localparam logic DEF_TXNRX_VAL = 1'b1;

  localparam int   TMR_WID       = 8;

  // A zero reload would make a timed state last forever; clamp to one cycle.
  function automatic logic [TMR_WID-1:0] cyc_to_tmr(input int cyc);
    if (cyc < 1) begin
      return TMR_WID'(1);
    end
    return TMR_WID'(cyc);
  endfunction

endpackage

// File: rtl/jesd207_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// jesd207_burst_ctrl_if
// Request/FIFO-status inputs and JESD207/FIFO control outputs of the burst
// controller.
//   slave  modport - the controller (takes req/abort/status, drives controls)
//   master modport - the requester / FIFO side
// Signals:
//   req, req_txnrx, burst_len, abort, rempty, wfull   (into controller)
//   tx_nrx, jesd_en, rd_en, wr_en, busy, done,
//   short_burst, xfer_cnt                              (out of controller)
// ---------------------------------------------------------------------------
interface jesd207_burst_ctrl_if #(
  parameter int CNT_WID = 16
) ();

  logic               req;
  logic               req_txnrx;
  logic [CNT_WID-1:0] burst_len;
  logic               abort;
  logic               rempty;
  logic               wfull;

  logic               tx_nrx;
  logic               jesd_en;
  logic               rd_en;
  logic               wr_en;
  logic               busy;
  logic               done;
  logic               short_burst;
  logic [CNT_WID-1:0] xfer_cnt;

  modport slave (
    input  req, req_txnrx, burst_len, abort, rempty, wfull,
    output tx_nrx, jesd_en, rd_en, wr_en, busy, done, short_burst, xfer_cnt
  );

  modport master (
    output req, req_txnrx, burst_len, abort, rempty, wfull,
    input  tx_nrx, jesd_en, rd_en, wr_en, busy, done, short_burst, xfer_cnt
  );

endinterface

// File: rtl/jesd207_cyc_timer.sv
// ---------------------------------------------------------------------------
// jesd207_cyc_timer
// Loadable down-counter used to time the SETUP, WAIT and GUARD states.
// A state that loads N on its entry edge sees expired in its Nth cycle.
// Ports:
//   fclk    in  control clock, active on the falling edge
//   rstn    in  asynchronous active-low reset
//   load    in  reload the counter with value on this edge
//   value   in  reload value (>=1)
//   expired out high in the last cycle of the timed interval
// ---------------------------------------------------------------------------
module jesd207_cyc_timer
  import jesd207_pkg::*;
#(
  parameter int WID = TMR_WID
) (
  input  logic           fclk,
  input  logic           rstn,
  input  logic           load,
  input  logic [WID-1:0] value,
  output logic           expired
);

  logic [WID-1:0] cnt_q;
  logic [WID-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge fclk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WID'(1));

endmodule

// File: rtl/jesd207_burst_ctrl.sv
// ---------------------------------------------------------------------------
// jesd207_burst_ctrl
// Sequences one JESD207 burst on the fclk side of the FIFO/RAM datapath:
// TXNRX setup, ENABLE strobes, lead-in to the FIFO enable, transfer counting
// and the guard interval before the next request.
// Ports:
//   fclk  in  control clock; every flop acts on the falling edge
//   rstn  in  asynchronous active-low reset
//   bus   jesd207_burst_ctrl_if.slave - req/abort/FIFO status in,
//         tx_nrx/jesd_en/rd_en/wr_en/busy/done/short_burst/xfer_cnt out
// Optional feature: JESD_LEVEL_MODE_EN
//   defined   - ENABLE held high from EN_ON until the burst stops
//   undefined - ENABLE pulsed for one cycle in EN_ON and again in STOP
// ---------------------------------------------------------------------------
module jesd207_burst_ctrl
  import jesd207_pkg::*;
#(
  parameter int   CNT_WID   = DEF_CNT_WID,
  parameter int   SETUP_CYC = DEF_SETUP_CYC,
  parameter int   LEAD_CYC  = DEF_LEAD_CYC,
  parameter int   GUARD_CYC = DEF_GUARD_CYC,
  parameter logic DEF_TXNRX = DEF_TXNRX_VAL
) (
  input  logic                fclk,
  input  logic                rstn,
  jesd207_burst_ctrl_if.slave bus
);

`ifdef JESD_LEVEL_MODE_EN
  localparam logic LEVEL_MODE = 1'b1;
`else
  localparam logic LEVEL_MODE = 1'b0;
`endif

  localparam logic [TMR_WID-1:0] SETUP_LD = cyc_to_tmr(SETUP_CYC);
  localparam logic [TMR_WID-1:0] LEAD_LD  = cyc_to_tmr(LEAD_CYC);
  localparam logic [TMR_WID-1:0] GUARD_LD = cyc_to_tmr(GUARD_CYC);

  // ENABLE value on entry to STOP: the closing pulse in pulse mode, the
  // falling edge in level mode.
  localparam logic STOP_JESD = ~LEVEL_MODE;

  state_e             state_q,   state_d;
  logic               tx_nrx_q,  tx_nrx_d;
  logic               jesd_en_q, jesd_en_d;
  logic               rd_en_q,   rd_en_d;
  logic               wr_en_q,   wr_en_d;
  logic               done_q,    done_d;
  logic               short_q,   short_d;
  logic [CNT_WID-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_WID-1:0] len_q,     len_d;

  logic               tmr_load;
  logic [TMR_WID-1:0] tmr_value;
  logic               tmr_expired;

  logic               moved;
  logic               fifo_stop;
  logic               len_hit;
  logic [CNT_WID-1:0] cnt_inc;

  jesd207_cyc_timer #(
    .WID     (TMR_WID)
  ) u_timer (
    .fclk    (fclk),
    .rstn    (rstn),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    tx_nrx_d   = tx_nrx_q;
    // Level mode keeps ENABLE where it is unless a state changes it.
    jesd_en_d  = LEVEL_MODE & jesd_en_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    short_d    = short_q;
    xfer_cnt_d = xfer_cnt_q;
    len_d      = len_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    // A word moves when the enable was high and the FIFO could accept/supply.
    moved     = tx_nrx_q ? (rd_en_q & ~bus.rempty) : (wr_en_q & ~bus.wfull);
    fifo_stop = tx_nrx_q ? bus.rempty : bus.wfull;
    cnt_inc   = (moved && (xfer_cnt_q != {CNT_WID{1'b1}})) ? xfer_cnt_q + 1'b1 : xfer_cnt_q;
    len_hit   = (len_q != '0) && (cnt_inc == len_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d    = ST_SETUP;
          tx_nrx_d   = bus.req_txnrx;
          len_d      = bus.burst_len;
          xfer_cnt_d = '0;
          short_d    = 1'b0;
          tmr_load   = 1'b1;
          tmr_value  = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (bus.abort) begin
          state_d   = ST_GUARD;
          done_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = GUARD_LD;
        end else if (tmr_expired) begin
          state_d   = ST_EN_ON;
          jesd_en_d = 1'b1;
        end
      end

      ST_EN_ON: begin
        if (bus.abort) begin
          state_d   = ST_STOP;
          jesd_en_d = STOP_JESD;
        end else begin
          state_d   = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_value = LEAD_LD;
        end
      end

      ST_WAIT: begin
        if (bus.abort) begin
          state_d   = ST_STOP;
          jesd_en_d = STOP_JESD;
        end else if (tmr_expired) begin
          state_d = ST_TRANS;
          rd_en_d = tx_nrx_q;
          wr_en_d = ~tx_nrx_q;
        end
      end

      ST_TRANS: begin
        xfer_cnt_d = cnt_inc;
        if (len_hit || fifo_stop || bus.abort) begin
          // The enable drops on the same edge that observes the stop cause.
          state_d   = ST_STOP;
          jesd_en_d = STOP_JESD;
          short_d   = fifo_stop && (len_q != '0) && !len_hit;
        end else begin
          rd_en_d = rd_en_q;
          wr_en_d = wr_en_q;
        end
      end

      ST_STOP: begin
        state_d   = ST_GUARD;
        jesd_en_d = 1'b0;
        done_d    = 1'b1;
        tmr_load  = 1'b1;
        tmr_value = GUARD_LD;
      end

      ST_GUARD: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge fclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tx_nrx_q   <= DEF_TXNRX;
      jesd_en_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      xfer_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_nrx_q   <= tx_nrx_d;
      jesd_en_q  <= jesd_en_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      short_q    <= short_d;
      xfer_cnt_q <= xfer_cnt_d;
      len_q      <= len_d;
    end
  end

  assign bus.tx_nrx      = tx_nrx_q;
  assign bus.jesd_en     = jesd_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.short_burst = short_q;
  assign bus.xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_jesd207_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jesd207_burst_ctrl
// Directed bursts against jesd207_burst_ctrl. Inputs are driven and outputs
// sampled on the rising edge, half a cycle away from the falling active edge.
// Expectations follow JESD_LEVEL_MODE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_jesd207_burst_ctrl;

  localparam int   CNT_WID   = 16;
  localparam int   SETUP_CYC = 2;
  localparam int   LEAD_CYC  = 2;
  localparam int   GUARD_CYC = 4;
  localparam logic DEF_TXNRX = 1'b1;

`ifdef JESD_LEVEL_MODE_EN
  localparam bit LEVEL = 1'b1;
`else
  localparam bit LEVEL = 1'b0;
`endif

  logic fclk;
  logic rstn;

  jesd207_burst_ctrl_if #(.CNT_WID(CNT_WID)) bus ();

  jesd207_burst_ctrl #(
    .CNT_WID   (CNT_WID),
    .SETUP_CYC (SETUP_CYC),
    .LEAD_CYC  (LEAD_CYC),
    .GUARD_CYC (GUARD_CYC),
    .DEF_TXNRX (DEF_TXNRX)
  ) dut (
    .fclk (fclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    fclk = 1'b1;
    forever #5 fclk = ~fclk;
  end

  int n_cmp;
  int n_fail;

  // Per-burst observations filled by drive_burst.
  int busy_cyc, setup_cyc, guard_cyc;
  int jesd_hi, jesd_rises;
  int rd_cyc, wr_cyc, done_hi, done_rises;
  int reads, writes;
  bit both_hi, txnrx_bad, timed_out, idle_bad;
  int xfer_final;
  bit short_final;

  // Run one burst from req to return to IDLE.
  //   empty_after/full_after: words moved before rempty/wfull rise (-1 = never)
  //   abort_mode: 0 none, 1 abort in first SETUP cycle, 2 abort in TRANS
  //   during the cycle that moves word abort_words
  //   inject_req: pulse req (opposite direction, len 1) in TRANS and in GUARD
  task automatic drive_burst(input logic tx, input int len, input int empty_after,
                             input int full_after, input int abort_mode,
                             input int abort_words, input bit inject_req);
    bit seen_busy, seen_j, seen_done, prev_j, prev_done, inj_t;
    busy_cyc = 0; setup_cyc = 0; guard_cyc = 0; jesd_hi = 0; jesd_rises = 0;
    rd_cyc = 0; wr_cyc = 0; done_hi = 0; done_rises = 0; reads = 0; writes = 0;
    both_hi = 0; txnrx_bad = 0; timed_out = 1; idle_bad = 0;
    seen_busy = 0; seen_j = 0; seen_done = 0; prev_j = 0; prev_done = 0; inj_t = 0;

    @(posedge fclk);
    bus.req       = 1'b1;
    bus.req_txnrx = tx;
    bus.burst_len = len[CNT_WID-1:0];
    bus.abort     = 1'b0;
    bus.rempty    = 1'b0;
    bus.wfull     = 1'b0;

    for (int c = 0; c < 300; c++) begin
      @(posedge fclk);
      bus.req   = 1'b0;
      bus.abort = 1'b0;
      if (bus.busy) begin
        busy_cyc++;
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.jesd_en) begin
        jesd_hi++;
        if (!prev_j) jesd_rises++;
        seen_j = 1'b1;
      end
      prev_j = bus.jesd_en;
      if (bus.busy && !seen_j) setup_cyc++;
      if (bus.busy && (bus.tx_nrx !== tx)) txnrx_bad = 1'b1;
      if (bus.rd_en) rd_cyc++;
      if (bus.wr_en) wr_cyc++;
      if (bus.rd_en && bus.wr_en) both_hi = 1'b1;
      if (bus.done) begin
        done_hi++;
        if (!prev_done) done_rises++;
        seen_done = 1'b1;
      end
      prev_done = bus.done;
      if (seen_done && bus.busy) guard_cyc++;

      // FIFO model: status for this cycle depends on words already moved.
      bus.rempty = (empty_after >= 0) && (reads >= empty_after);
      bus.wfull  = (full_after >= 0) && (writes >= full_after);
      if (abort_mode == 1 && bus.busy && !seen_j && setup_cyc == 1) bus.abort = 1'b1;
      if (abort_mode == 2 && bus.rd_en && !bus.rempty && reads == abort_words - 1) bus.abort = 1'b1;
      if (bus.rd_en && !bus.rempty) reads++;
      if (bus.wr_en && !bus.wfull) writes++;

      if (inject_req && (bus.rd_en || bus.wr_en) && !inj_t) begin
        bus.req = 1'b1; bus.req_txnrx = ~tx; bus.burst_len = 16'd1; inj_t = 1'b1;
      end
      if (inject_req && bus.done) begin
        bus.req = 1'b1; bus.req_txnrx = ~tx;
      end
    end

    bus.rempty = 1'b0;
    bus.wfull  = 1'b0;
    xfer_final  = int'(bus.xfer_cnt);
    short_final = bus.short_burst;
    for (int i = 0; i < 4; i++) begin
      @(posedge fclk);
      if (bus.busy) idle_bad = 1'b1;
    end
    $display("burst tx=%0d len=%0d: busy=%0d setup=%0d jesd_hi=%0d rises=%0d rd=%0d wr=%0d xfer=%0d short=%0d guard=%0d",
             tx, len, busy_cyc, setup_cyc, jesd_hi, jesd_rises, rd_cyc, wr_cyc,
             xfer_final, short_final, guard_cyc);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.req = 1'b0; bus.req_txnrx = 1'b0; bus.burst_len = '0;
    bus.abort = 1'b0; bus.rempty = 1'b0; bus.wfull = 1'b0;
    repeat (3) @(posedge fclk);
    n_cmp++; if (bus.tx_nrx !== DEF_TXNRX) begin n_fail++; $display("FAIL reset_tx_nrx: got %b want %b", bus.tx_nrx, DEF_TXNRX); end
    n_cmp++; if (bus.jesd_en !== 1'b0) begin n_fail++; $display("FAIL reset_jesd_en: got %b want 0", bus.jesd_en); end
    n_cmp++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.short_burst !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b want 0", bus.short_burst); end
    n_cmp++; if (bus.xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_xfer_cnt: got %0d want 0", bus.xfer_cnt); end
    rstn = 1'b1;
    repeat (2) @(posedge fclk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
    $display("reset: checked outputs during and after reset");
  endtask

  // RX, unlimited length, FIFO fills after 5 writes.
  task automatic test_rx_full();
    drive_burst(1'b0, 0, -1, 5, 0, 0, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rx_timeout: got 1 want 0"); end
    n_cmp++; if (xfer_final != 5) begin n_fail++; $display("FAIL rx_xfer_cnt: got %0d want 5", xfer_final); end
    n_cmp++; if (wr_cyc != 6) begin n_fail++; $display("FAIL rx_wr_cycles: got %0d want 6", wr_cyc); end
    n_cmp++; if (rd_cyc != 0) begin n_fail++; $display("FAIL rx_rd_cycles: got %0d want 0", rd_cyc); end
    n_cmp++; if (short_final !== 1'b0) begin n_fail++; $display("FAIL rx_short: got %b want 0", short_final); end
    n_cmp++; if (busy_cyc != 16) begin n_fail++; $display("FAIL rx_busy_cycles: got %0d want 16", busy_cyc); end
    n_cmp++; if (txnrx_bad) begin n_fail++; $display("FAIL rx_tx_nrx: got mismatch want 0"); end
    n_cmp++; if (bus.tx_nrx !== 1'b0) begin n_fail++; $display("FAIL rx_tx_nrx_held: got %b want 0", bus.tx_nrx); end
    n_cmp++; if (jesd_hi != (LEVEL ? 9 : 2)) begin n_fail++; $display("FAIL rx_jesd_hi: got %0d want %0d", jesd_hi, LEVEL ? 9 : 2); end
  endtask

  // TX, length 8, FIFO never empty.
  task automatic test_tx_len8();
    drive_burst(1'b1, 8, -1, -1, 0, 0, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL tx8_timeout: got 1 want 0"); end
    n_cmp++; if (setup_cyc != 2) begin n_fail++; $display("FAIL tx8_setup_cycles: got %0d want 2", setup_cyc); end
    n_cmp++; if (txnrx_bad) begin n_fail++; $display("FAIL tx8_tx_nrx: got mismatch want 0"); end
    n_cmp++; if (rd_cyc != 8) begin n_fail++; $display("FAIL tx8_rd_cycles: got %0d want 8", rd_cyc); end
    n_cmp++; if (xfer_final != 8) begin n_fail++; $display("FAIL tx8_xfer_cnt: got %0d want 8", xfer_final); end
    n_cmp++; if (short_final !== 1'b0) begin n_fail++; $display("FAIL tx8_short: got %b want 0", short_final); end
    n_cmp++; if (done_rises != 1 || done_hi != 1) begin n_fail++; $display("FAIL tx8_done: got %0d/%0d want 1/1", done_rises, done_hi); end
    n_cmp++; if (jesd_rises != (LEVEL ? 1 : 2)) begin n_fail++; $display("FAIL tx8_jesd_rises: got %0d want %0d", jesd_rises, LEVEL ? 1 : 2); end
    n_cmp++; if (jesd_hi != (LEVEL ? 11 : 2)) begin n_fail++; $display("FAIL tx8_jesd_hi: got %0d want %0d", jesd_hi, LEVEL ? 11 : 2); end
    n_cmp++; if (busy_cyc != 18) begin n_fail++; $display("FAIL tx8_busy_cycles: got %0d want 18", busy_cyc); end
    n_cmp++; if (both_hi) begin n_fail++; $display("FAIL tx8_rd_wr_both: got 1 want 0"); end
  endtask

  // TX, length 10, FIFO runs empty after 4 reads.
  task automatic test_tx_empty();
    drive_burst(1'b1, 10, 4, -1, 0, 0, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL txe_timeout: got 1 want 0"); end
    n_cmp++; if (xfer_final != 4) begin n_fail++; $display("FAIL txe_xfer_cnt: got %0d want 4", xfer_final); end
    n_cmp++; if (rd_cyc != 5) begin n_fail++; $display("FAIL txe_rd_cycles: got %0d want 5", rd_cyc); end
    n_cmp++; if (short_final !== 1'b1) begin n_fail++; $display("FAIL txe_short: got %b want 1", short_final); end
    n_cmp++; if (jesd_rises != (LEVEL ? 1 : 2)) begin n_fail++; $display("FAIL txe_jesd_rises: got %0d want %0d", jesd_rises, LEVEL ? 1 : 2); end
    n_cmp++; if (jesd_hi != (LEVEL ? 8 : 2)) begin n_fail++; $display("FAIL txe_jesd_hi: got %0d want %0d", jesd_hi, LEVEL ? 8 : 2); end
  endtask

  task automatic test_abort_setup();
    drive_burst(1'b1, 8, -1, -1, 1, 0, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL abs_timeout: got 1 want 0"); end
    n_cmp++; if (jesd_hi != 0) begin n_fail++; $display("FAIL abs_jesd_hi: got %0d want 0", jesd_hi); end
    n_cmp++; if (rd_cyc != 0 || wr_cyc != 0) begin n_fail++; $display("FAIL abs_enables: got %0d/%0d want 0/0", rd_cyc, wr_cyc); end
    n_cmp++; if (done_rises != 1) begin n_fail++; $display("FAIL abs_done: got %0d want 1", done_rises); end
    n_cmp++; if (guard_cyc != 4) begin n_fail++; $display("FAIL abs_guard_cycles: got %0d want 4", guard_cyc); end
    n_cmp++; if (busy_cyc != 5) begin n_fail++; $display("FAIL abs_busy_cycles: got %0d want 5", busy_cyc); end
    n_cmp++; if (short_final !== 1'b0) begin n_fail++; $display("FAIL abs_short_cleared: got %b want 0", short_final); end
  endtask

  // Abort is raised in the cycle that moves the 3rd word.
  task automatic test_abort_trans();
    drive_burst(1'b1, 0, -1, -1, 2, 3, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL abt_timeout: got 1 want 0"); end
    n_cmp++; if (xfer_final != 3) begin n_fail++; $display("FAIL abt_xfer_cnt: got %0d want 3", xfer_final); end
    n_cmp++; if (rd_cyc != 3) begin n_fail++; $display("FAIL abt_rd_cycles: got %0d want 3", rd_cyc); end
    n_cmp++; if (short_final !== 1'b0) begin n_fail++; $display("FAIL abt_short: got %b want 0", short_final); end
    n_cmp++; if (jesd_rises != (LEVEL ? 1 : 2)) begin n_fail++; $display("FAIL abt_jesd_rises: got %0d want %0d", jesd_rises, LEVEL ? 1 : 2); end
    n_cmp++; if (guard_cyc != 4) begin n_fail++; $display("FAIL abt_guard_cycles: got %0d want 4", guard_cyc); end
  endtask

  // Requests in TRANS and GUARD must not alter or restart the burst.
  task automatic test_req_ignored();
    drive_burst(1'b1, 6, -1, -1, 0, 0, 1'b1);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL req_timeout: got 1 want 0"); end
    n_cmp++; if (xfer_final != 6) begin n_fail++; $display("FAIL req_xfer_cnt: got %0d want 6", xfer_final); end
    n_cmp++; if (txnrx_bad || bus.tx_nrx !== 1'b1) begin n_fail++; $display("FAIL req_tx_nrx: got %b want 1", bus.tx_nrx); end
    n_cmp++; if (wr_cyc != 0) begin n_fail++; $display("FAIL req_wr_cycles: got %0d want 0", wr_cyc); end
    n_cmp++; if (idle_bad) begin n_fail++; $display("FAIL req_restart: got busy want idle"); end
  endtask

  // Asynchronous reset in the middle of TRANS, for both directions.
  task automatic test_reset_mid();
    for (int d = 0; d < 2; d++) begin
      logic tx;
      bit   got;
      tx = (d == 0);
      got = 1'b0;
      @(posedge fclk);
      bus.req = 1'b1; bus.req_txnrx = tx; bus.burst_len = '0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(posedge fclk);
        bus.req = 1'b0;
        got = bus.rd_en | bus.wr_en;
      end
      n_cmp++; if (!got) begin n_fail++; $display("FAIL rstmid_reach_trans[%0d]: got 0 want 1", d); end
      repeat (2) @(posedge fclk);
      rstn = 1'b0;
      #1;
      n_cmp++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_enables[%0d]: got %b%b want 00", d, bus.rd_en, bus.wr_en); end
      n_cmp++; if (bus.jesd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_jesd_en[%0d]: got %b want 0", d, bus.jesd_en); end
      n_cmp++; if (bus.tx_nrx !== DEF_TXNRX) begin n_fail++; $display("FAIL rstmid_tx_nrx[%0d]: got %b want %b", d, bus.tx_nrx, DEF_TXNRX); end
      n_cmp++; if (bus.busy !== 1'b0 || bus.xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_state[%0d]: got busy=%b xfer=%0d want 0/0", d, bus.busy, bus.xfer_cnt); end
      $display("reset mid-TRANS tx=%0d applied", tx);
      @(posedge fclk);
      rstn = 1'b1;
      repeat (2) @(posedge fclk);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_rx_full();
    test_tx_len8();
    test_tx_empty();
    test_abort_setup();
    test_abort_trans();
    test_req_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
